// File: rtl/motion_highlight.sv
// Motion highlighter: pops mask/frame pixel pairs from two FWFT FIFOs, substitutes
// HIGHLIGHT_COLOR on motion pixels, and reports the per-frame motion pixel count.
module motion_highlight #(
    parameter int          WIDTH           = 720,
    parameter int          HEIGHT          = 540,
    parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000,
    parameter int          CNT_W           = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             mask_rd_en,
    input  logic             mask_empty,
    input  logic [23:0]      mask_dout,
    output logic             img_rd_en,
    input  logic             img_empty,
    input  logic [23:0]      img_dout,
    output logic             out_wr_en,
    input  logic             out_full,
    output logic [23:0]      out_din,
    output logic [CNT_W-1:0] motion_count,
    output logic             frame_done
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [23:0]        pix;
    logic               is_motion;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_c;
    logic               frame_end;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; combinational blocks below use blocking ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_READ;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    // Strobes are gated by reset so no FIFO is touched while reset is held.
    always_comb begin
        state_n    = state;
        mask_rd_en = 1'b0;
        img_rd_en  = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = '0;
        if (!reset) begin
            case (state)
                S_READ: begin
                    // Both streams must advance in lockstep to stay pixel-aligned.
                    if (!mask_empty && !img_empty) begin
                        mask_rd_en = 1'b1;
                        img_rd_en  = 1'b1;
                        state_n    = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!out_full) begin
                        out_wr_en = 1'b1;
                        out_din   = pix;
                        state_n   = S_READ;
                    end
                end
                default: state_n = S_READ;
            endcase
        end
    end

    assign count_c   = count + CNT_W'(is_motion);
    assign frame_end = out_wr_en && (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix          <= '0;
            is_motion    <= 1'b0;
            col          <= '0;
            row          <= '0;
            count        <= '0;
            motion_count <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (mask_rd_en) begin
                pix       <= (mask_dout != 24'h0) ? HIGHLIGHT_COLOR : img_dout;
                is_motion <= (mask_dout != 24'h0);
            end
            if (out_wr_en) begin
                if (frame_end) begin
                    motion_count <= count_c;
                    count        <= '0;
                    col          <= '0;
                    row          <= '0;
                end else begin
                    count <= count_c;
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule
